// File: rtl/inv_mix_columns_iter_pkg.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_iter_pkg
// Shared AES InvMixColumns definitions:
//   INV_MC_ROW0..3 : rows of the inverse MixColumns matrix, byte 0 in [31:24]
//   state_e        : FSM states of the iterative unit (IDLE/BUSY/DONE)
//   xtime()        : multiply a GF(2^8) element by x, reduction poly 0x11B
//   inv_mc_row()   : row constant selected by row index
// -----------------------------------------------------------------------------
package inv_mix_columns_iter_pkg;

  localparam logic [31:0] INV_MC_ROW0 = 32'h0e0b0d09;
  localparam logic [31:0] INV_MC_ROW1 = 32'h090e0b0d;
  localparam logic [31:0] INV_MC_ROW2 = 32'h0d090e0b;
  localparam logic [31:0] INV_MC_ROW3 = 32'h0b0d090e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mc_row(input int r);
    logic [31:0] row;
    case (r)
      0:       row = INV_MC_ROW0;
      1:       row = INV_MC_ROW1;
      2:       row = INV_MC_ROW2;
      default: row = INV_MC_ROW3;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/inv_mc_step1.sv
// -----------------------------------------------------------------------------
// inv_mc_step1
// Combinational single-byte InvMixColumns step: one output byte of a column,
// res = XOR over k of gmul(row[k], col[k]) in GF(2^8), poly 0x11B.
// Ports:
//   col [31:0] in   column, byte 0 in [31:24]
//   row [31:0] in   matrix row constants, byte 0 in [31:24]
//   res [7:0]  out  resulting byte
// -----------------------------------------------------------------------------
module inv_mc_step1
  import inv_mix_columns_iter_pkg::*;
(
  input  logic [31:0] col,
  input  logic [31:0] row,
  output logic [7:0]  res
);

  // Constant multiply as a chain of xtime terms: each set bit i of the
  // constant contributes x^i * b. With a fixed row this folds down to the
  // x8^x / x8^x2^x / x8^x4^x / x8^x4^x2 networks, higher terms vanish.
  function automatic logic [7:0] gmul_const(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

  always_comb begin
    res = 8'h00;
    for (int k = 0; k < 4; k++) begin
      res = res ^ gmul_const(row[31-8*k -: 8], col[31-8*k -: 8]);
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_iter
// Iterative AES InvMixColumns unit. Accepts a 128-bit state on a valid/ready
// handshake, computes COLS_PER_CYCLE columns per BUSY cycle and holds the
// registered result until the consumer takes it.
// Parameters:
//   COLS_PER_CYCLE  columns computed per BUSY cycle (1, 2 or 4)
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data valid
//   in_ready   out  unit can accept a state (IDLE only)
//   in_data    in   state, column c = in_data[127-32c -: 32], byte 0 = MSB
//   out_valid  out  out_data valid (DONE)
//   out_ready  in   consumer accepts out_data
//   out_data   out  InvMixColumns(state), same byte/column order
// -----------------------------------------------------------------------------
module inv_mix_columns_iter
  import inv_mix_columns_iter_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // col_cnt value at which the final column group is being computed
  localparam int unsigned LAST_BASE = 4 - COLS_PER_CYCLE;

  state_e      state_q;
  state_e      state_d;
  logic        rdy_en_q;
  logic [2:0]  col_cnt_q;
  logic [31:0] work_q [4];
  logic [31:0] res_q  [4];

  logic        load_en;
  logic        step_en;
  logic        last_grp;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] sel_col [COLS_PER_CYCLE];
  logic [COLS_PER_CYCLE-1:0][3:0][7:0] mc_byte;

  assign last_grp = (col_cnt_q == 3'(LAST_BASE));

  // ---- control state register ----
  // rdy_en_q is cleared by reset and set on the first clock afterwards, so
  // in_ready stays low while rst_n is asserted even though the FSM sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // ---- next state and handshake outputs ----
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = rdy_en_q;
        if (in_valid && rdy_en_q) begin
          load_en = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step_en = 1'b1;
        if (last_grp) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- column select for the current group ----
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx[g] = col_cnt_q[1:0] + 2'(g);
      sel_col[g] = work_q[col_idx[g]];
    end
  end

  // ---- per-byte GF(2^8) networks: 4 rows x COLS_PER_CYCLE columns ----
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam logic [31:0] ROW = inv_mc_row(r);
      inv_mc_step1 u_step (
        .col (sel_col[g]),
        .row (ROW),
        .res (mc_byte[g][3-r])
      );
    end
  end

  // ---- work / result registers ----
  // Every column of res_q is rewritten during BUSY, so a new state never
  // mixes with columns left over from an earlier or aborted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        work_q[i] <= 32'h0;
        res_q[i]  <= 32'h0;
      end
    end else if (load_en) begin
      col_cnt_q <= 3'd0;
      work_q[0] <= in_data[127:96];
      work_q[1] <= in_data[95:64];
      work_q[2] <= in_data[63:32];
      work_q[3] <= in_data[31:0];
    end else if (step_en) begin
      col_cnt_q <= col_cnt_q + 3'(COLS_PER_CYCLE);
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        res_q[col_idx[g]] <= mc_byte[g];
      end
    end
  end

  assign out_data = {res_q[0], res_q[1], res_q[2], res_q[3]};

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_iter
// Bench for inv_mix_columns_iter with three instances (1, 2 and 4 columns per
// cycle) sharing clock and reset. Expected values come from fixed vectors and
// from a GF(2^8) polynomial-arithmetic model of (Inv)MixColumns.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_data   [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_data  [NI];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vt [5];

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  // ---- reference model: carry-less product reduced modulo 0x11B ----
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix (first row c0..c3) applied to each column of a state.
  function automatic logic [127:0] apply_mat(input logic [127:0] s,
                                             input logic [7:0] c0, input logic [7:0] c1,
                                             input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0]   st [16];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] t;
    logic [127:0] o;
    cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3;
    t = s;
    for (int i = 0; i < 16; i++) begin
      st[i] = t[127:120];
      t = t << 8;
    end
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(cf[2'(k - r)], st[4'(4 * c + k)]);
        o = {o[119:0], acc};
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    return apply_mat(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return apply_mat(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance k with latency and handshake checks.
  task automatic run(input int k, input logic [127:0] din, input logic [127:0] exp,
                     input string name);
    int w;
    int lat;
    w = 0;
    while (in_ready[k] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({name, " in_ready"}, 128'(in_ready[k]), 128'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = din;
    tick();
    in_valid[k] = 1'b0;
    in_data[k]  = ~din;
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, 128'(lat), 128'(4 >> k));
    chk({name, " data"}, out_data[k], exp);
    chk({name, " in_ready_done"}, 128'(in_ready[k]), 128'd0);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({name, " out_valid_drop"}, 128'(out_valid[k]), 128'd0);
  endtask

  task automatic b2b(input int k, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ins [2];
    logic [127:0] got [$];
    int           acc_cyc [2];
    int           sent;
    int           cyc;
    logic         hs_in;
    logic         hs_out;
    ins[0] = a;
    ins[1] = b;
    sent = 0;
    cyc = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b1;
    in_data[k]   = ins[0];
    while (got.size() < 2 && cyc < 60) begin
      hs_in  = in_valid[k] && in_ready[k];
      hs_out = out_valid[k] && out_ready[k];
      if (out_valid[k]) chk($sformatf("b2b%0d bubble", k), 128'(in_ready[k]), 128'd0);
      if (hs_out) got.push_back(out_data[k]);
      tick();
      cyc++;
      if (hs_in) begin
        acc_cyc[sent] = cyc;
        sent++;
        if (sent < 2) in_data[k] = ins[sent];
        else in_valid[k] = 1'b0;
      end
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    chk($sformatf("b2b%0d count", k), 128'(got.size()), 128'd2);
    if (got.size() == 2) begin
      chk($sformatf("b2b%0d first", k), got[0], ref_inv(a));
      chk($sformatf("b2b%0d second", k), got[1], ref_inv(b));
    end
    chk($sformatf("b2b%0d period", k), 128'(acc_cyc[1] - acc_cyc[0]), 128'((4 >> k) + 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x;
    logic [127:0] hold;
    int           k;
    bit           seen;

    vt[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vt[1] = '{128'h4d7ebdf8_d5d5d7d6_8e4da1bc_01010101, 128'h2d26314c_d4d4d4d5_db135345_01010101};
    vt[2] = '{128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_9fdc589d, 128'hd4d4d4d5_2d26314c_c6c6c6c6_f20a225c};
    vt[3] = '{128'h0, 128'h0};
    vt[4] = '{128'h01010101_8e4da1bc_4d7ebdf8_d5d5d7d6, 128'h01010101_db135345_2d26314c_d4d4d4d5};

    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 128'h0;
      out_ready[i] = 1'b0;
    end

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d out_valid", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("rst%0d out_data", i), out_data[i], 128'h0);
      chk($sformatf("rst%0d in_ready", i), 128'(in_ready[i]), 128'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++)
      chk($sformatf("rel%0d in_ready", i), 128'(in_ready[i]), 128'd1);

    // Fixed vectors on every instance
    for (int v = 0; v < 5; v++)
      for (int i = 0; i < NI; i++)
        run(i, vt[v].din, vt[v].exp, $sformatf("vec%0d_i%0d", v, i));

    // Backpressure: DONE held for 10 cycles with a competing in_valid
    in_valid[0] = 1'b1;
    in_data[0]  = vt[1].din;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    chk("bp out_valid", 128'(out_valid[0]), 128'd1);
    hold = out_data[0];
    chk("bp data", hold, vt[1].exp);
    in_valid[0] = 1'b1;
    in_data[0]  = vt[0].din;
    for (int i = 0; i < 10; i++) begin
      chk("bp hold_valid", 128'(out_valid[0]), 128'd1);
      chk("bp hold_data", out_data[0], vt[1].exp);
      chk("bp hold_in_ready", 128'(in_ready[0]), 128'd0);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0]) seen = 1'b1;
      tick();
    end
    chk("bp not_latched", 128'(seen), 128'd0);

    // Back-to-back with continuous valid/ready
    b2b(0, vt[0].din, vt[2].din);
    b2b(1, vt[1].din, vt[4].din);
    b2b(2, vt[4].din, vt[0].din);

    // Asynchronous reset in the middle of BUSY
    in_valid[0] = 1'b1;
    in_data[0]  = vt[2].din;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 128'(out_valid[0]), 128'd0);
    chk("arst out_data", out_data[0], 128'h0);
    chk("arst in_ready", 128'(in_ready[0]), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("arst in_ready_hold", 128'(in_ready[0]), 128'd0);
    tick();
    chk("arst in_ready_rel", 128'(in_ready[0]), 128'd1);
    chk("arst idle_valid", 128'(out_valid[0]), 128'd0);
    run(0, vt[4].din, vt[4].exp, "arst_next");

    // Random states against the model
    for (int i = 0; i < 1000; i++) begin
      k = i % NI;
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i % 2 == 0) run(k, ref_mix(x), x, $sformatf("rt%0d", i));
      else run(k, x, ref_inv(x), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
